ysyx_23060332_mem_arbiter: RTL
==============================

YSYX_23060332_MEM_ARBITER -- requirements
Module: ysyx_23060332_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 64, data width.
REQ-003 SHALL have parameter TIMEOUT, 16, maximum WAIT cycles before an error response (TIMEOUT >= 2).
REQ-004 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have IFU ports: ifu_req_valid in 1; ifu_req_ready out 1; ifu_addr in ADDR_W; ifu_rsp_valid out 1; ifu_rdata out DATA_W.
REQ-007 SHALL have LSU ports: lsu_req_valid in 1; lsu_req_ready out 1; lsu_wen in 1; lsu_addr in ADDR_W; lsu_wdata in DATA_W; lsu_wmask in DATA_W/8; lsu_rsp_valid out 1; lsu_rdata out DATA_W.
REQ-008 SHALL have memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_wen out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_wmask out DATA_W/8; mem_rsp_valid in 1; mem_rdata in DATA_W.
REQ-009 SHALL have port rsp_err  out  1  qualifies the current ifu_rsp_valid/lsu_rsp_valid as a timeout error.

Function
REQ-010 SHALL share one memory port between IFU (read-only) and LSU (read/write), with one outstanding transaction at a time.
REQ-011 SHALL implement states IDLE, REQ, WAIT.
REQ-012 IDLE: at most one of ifu_req_ready/lsu_req_ready SHALL be 1, combinationally, for the granted requester only; both SHALL be 0 in REQ and WAIT.
REQ-013 Grant: only one valid -> that one; both valid -> the requester not granted last (last_owner register, reset to IFU, so first conflict goes to LSU).
REQ-014 On handshake (valid && ready) in IDLE, SHALL latch addr/wen/wdata/wmask and owner, update last_owner, go to REQ; IFU transactions SHALL latch wen=0, wmask=0, wdata=0.
REQ-015 REQ: mem_req_valid=1 and mem_* driven from latched registers, stable until mem_req_ready=1; then go to WAIT, clear timeout counter.
REQ-016 WAIT: mem_rsp_valid=1 -> register mem_rdata into owner's rdata, pulse owner's rsp_valid for exactly 1 cycle (next cycle), rsp_err=0, go to IDLE.
REQ-017 WAIT: counter increments each cycle without mem_rsp_valid; reaching TIMEOUT-1 -> owner's rsp_valid pulse with rsp_err=1, rdata=0, go to IDLE.
REQ-018 The cycle a rsp_valid pulse is visible SHALL be an IDLE cycle; a new grant in that same cycle SHALL be permitted.
REQ-019 mem_rsp_valid in IDLE or REQ SHALL be ignored (no response, no state change).
REQ-020 Minimum latency: handshake cycle N, mem_req_valid cycle N+1, with mem_req_ready=1 and mem_rsp_valid at N+2 -> rsp_valid at N+3.
REQ-021 Non-owner rsp_valid SHALL remain 0; rdata outputs SHALL hold last value between responses.
REQ-022 Requester inputs changing outside the handshake cycle SHALL not affect an in-flight transaction.

Reset
REQ-023 rst=1 SHALL immediately (no clock) force IDLE, last_owner=IFU, counter=0, all outputs and latched registers 0.
REQ-024 Reset mid-REQ/WAIT SHALL abort the transaction; any later mem_rsp_valid SHALL be ignored per REQ-019, no response issued.

Verification
REQ-025 IFU read alone: ifu_req_valid, addr=0x80000000, mem ready immediate, rdata=0x0000_0013_0000_0093 one cycle later -> ifu_rsp_valid at N+3 with that data, rsp_err=0.
REQ-026 LSU write: addr=0x80001000, wdata=0xDEADBEEF_CAFEF00D, wmask=0x0F, mem_req_ready delayed 3 cycles -> mem_* stable all 3 cycles, mem_wen=1, lsu_rsp_valid single pulse.
REQ-027 Simultaneous IFU+LSU valid from reset, held for 4 transactions -> grant order LSU, IFU, LSU, IFU; never both ready.
REQ-028 Timeout: mem never asserts mem_rsp_valid, TIMEOUT=16 -> owner rsp_valid with rsp_err=1, rdata=0, 16 cycles after entering WAIT; then IDLE.
REQ-029 Reset asserted mid-WAIT (between edges) -> mem_req_valid/ready outputs 0 immediately; late mem_rsp_valid after release -> no rsp_valid.
REQ-030 Spurious mem_rsp_valid in IDLE -> no rsp_valid, state unchanged.

Source files
------------

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Two-master memory arbiter: IFU (read-only) and LSU (read/write) share one
// memory port, one transaction in flight, IDLE -> REQ -> WAIT -> IDLE.
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  rsp_err,
    output logic [1:0]            o_dbg_state
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t              r_state;
    owner_t              r_owner;
    owner_t              r_last_owner;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_mem_req_valid;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                r_ifu_rsp_valid;
    logic                r_lsu_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_ifu_rdata;
    logic [DATA_W-1:0]   r_lsu_rdata;

    logic                w_idle;
    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_timeout;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both 1. Requesters hold valid until accepted; ready here depends on
    // valid (IDLE grant), never the other way round. mem_req_valid is held
    // with stable payload until mem_req_ready; mem_rsp_valid is a one-cycle
    // strobe honoured only in WAIT.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_grant_lsu = w_idle && lsu_req_valid &&
                         (!ifu_req_valid || (r_last_owner == OWN_IFU));
    assign w_grant_ifu = w_idle && ifu_req_valid &&
                         (!lsu_req_valid || (r_last_owner == OWN_LSU));
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_wen       = r_wen;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    assign ifu_rsp_valid = r_ifu_rsp_valid;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign ifu_rdata     = r_ifu_rdata;
    assign lsu_rdata     = r_lsu_rdata;
    assign rsp_err       = r_rsp_err;
    assign o_dbg_state   = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_owner         <= OWN_IFU;
            r_last_owner    <= OWN_IFU;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_wen           <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_ifu_rdata     <= '0;
            r_lsu_rdata     <= '0;
        end else begin
            // Response strobes are single-cycle pulses by default.
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_rsp_err       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_lsu) begin
                        r_addr          <= lsu_addr;
                        r_wen           <= lsu_wen;
                        r_wdata         <= lsu_wdata;
                        r_wmask         <= lsu_wmask;
                        r_owner         <= OWN_LSU;
                        r_last_owner    <= OWN_LSU;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end else if (w_grant_ifu) begin
                        r_addr          <= ifu_addr;
                        r_wen           <= 1'b0;
                        r_wdata         <= '0;
                        r_wmask         <= '0;
                        r_owner         <= OWN_IFU;
                        r_last_owner    <= OWN_IFU;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (r_owner == OWN_LSU) begin
                            r_lsu_rdata     <= mem_rdata;
                            r_lsu_rsp_valid <= 1'b1;
                        end else begin
                            r_ifu_rdata     <= mem_rdata;
                            r_ifu_rsp_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        // Memory never answered: report an error with zero data.
                        if (r_owner == OWN_LSU) begin
                            r_lsu_rdata     <= '0;
                            r_lsu_rsp_valid <= 1'b1;
                        end else begin
                            r_ifu_rdata     <= '0;
                            r_ifu_rsp_valid <= 1'b1;
                        end
                        r_rsp_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
